adder_result_serializer: RTL
============================

Name: adder_result_serializer

Overview:
- Downstream stage of the 4-bit adder; consumes its 5-bit result word z[4:0].
- Buffers results in a small FIFO and shifts each one out on a single framed serial line, LSB first.
- Lets a Tiny-Tapeout-style tile expose adder results on one output pin at the adder's own issue rate.

Parameters:
- DATA_W, 5, result word width; matches the adder z output.
- DEPTH, 4, FIFO depth in words; must be a power of 2, minimum 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- ena  input  1  global enable; when 0, all state holds.
- in_valid  input  1  adder result present on in_data.
- in_data  input  DATA_W  adder result z[4:0].
- in_ready  output  1  combinational: ena & !full.
- ser_out  output  1  registered serial line; idles high.
- ser_busy  output  1  registered; 1 whenever the FSM is not in IDLE.
- overflow  output  1  sticky; set when a word is dropped.
- count  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (sync, active-high): clears all state. ser_out=1, ser_busy=0, overflow=0, count=0, FSM=IDLE, FIFO empty.
- Reset mid-frame: aborts the frame; ser_out=1 from the next edge; buffered words are discarded.
- ena=0 freezes everything: FSM, shift register, bit counter, FIFO pointers, overflow and ser_out. Because in_ready=0, no push occurs.
- Push: occurs on an edge where in_valid & in_ready.
- Drop: in_valid & ena & full sets overflow; the word is discarded.
- full and in_ready use the registered count. A pop in the same cycle does not make room for a push.
- Simultaneous push and pop on a non-full FIFO: count is unchanged, and both operations take effect.
- Frame format, one bit per enabled cycle: start bit 0, then DATA_W data bits LSB first, then stop bit 1. Frame length = DATA_W+2 = 7 cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if count>0, pop into shift reg and go to START; otherwise stay with ser_out=1.
  - START: ser_out=0 for one cycle; then go to DATA with bit index 0.
  - DATA: ser_out=shift[0]; shift right each cycle; after bit DATA_W-1 go to STOP.
  - STOP: ser_out=1 for one cycle. If count>0, pop and go directly to START, giving back-to-back frames with no idle gap. Otherwise go to IDLE.
- Latency: a word pushed at edge N into an empty FIFO with the FSM in IDLE is popped at edge N+1. Its start bit is visible after edge N+1, its data bits after edges N+2 to N+6, and its stop bit after edge N+7.
- ser_busy=1 in START, DATA and STOP.
- count is 0..DEPTH. Pointers wrap modulo DEPTH.
- overflow clears only on reset.

Decomposition:
- Package adder_ser_pkg:
  - DATA_W constant.
  - START_BIT=0 and STOP_BIT=1.
  - FSM state enum {IDLE, START, DATA, STOP}.
  - FRAME_LEN = DATA_W+2.
- Sub-module result_fifo: sync FIFO with push/pop/full/empty/count, parameterised by DATA_W and DEPTH. The top level holds the FSM, the shift register and the overflow flag.

Test Plan:
- Single word: reset, then push in_data=5'b10110 once → ser_out after successive edges = 0,0,1,1,0,1,1, then stays 1. ser_busy is high for exactly 7 cycles. count goes 1→0 at the pop.
- Back-to-back: push 3'b…: 5'h01, 5'h1F, 5'h0A on 3 consecutive cycles → three contiguous 7-bit frames with no idle gap. Data bits are 10000, 11111, 01010. count never exceeds 2.
- Overflow: push 6 words on 6 consecutive cycles → count follows 1,1,2,3,4 and in_ready=0 at the 6th cycle. The 6th word is dropped and overflow=1. Exactly 5 frames are emitted. overflow stays 1 until reset.
- Enable freeze: drop ena to 0 for 3 cycles during DATA bit 2 → ser_out holds bit 2 for 3 extra cycles. in_ready=0 and pushes are ignored. The frame completes correctly after ena returns to 1.
- Reset mid-frame: assert reset during DATA with 2 words queued → the next cycle shows ser_out=1, ser_busy=0, count=0, overflow=0. No further frames are emitted.
- Wrap-around: 10 words pushed with spacing so that count stays ≤3 → all 10 frames are emitted in order with correct data, exercising pointer wrap at DEPTH=4.

Source files
------------

// File: rtl/adder_ser_pkg.sv
// Shared constants and FSM state type for the adder result serializer.
package adder_ser_pkg;

  localparam int DATA_W    = 5;
  localparam int FRAME_LEN = DATA_W + 2;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } ser_state_t;

endpackage

// File: rtl/adder_result_serializer_fifo.sv
// Synchronous FIFO holding adder results until the serializer can frame them.
module result_fifo #(
  parameter int DATA_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wr_data,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_q;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/adder_result_serializer.sv
// Buffers adder results and shifts each out as a start/data(LSB first)/stop frame.
//   state | meaning
//   IDLE  | line high, waiting for a buffered word
//   START | start bit on the line
//   DATA  | data bits on the line, LSB first
//   STOP  | stop bit on the line; may pop the next word for a gapless frame
module adder_result_serializer #(
  parameter int DATA_W = adder_ser_pkg::DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ena,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_data,
  output logic                   in_ready,
  output logic                   ser_out,
  output logic                   ser_busy,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] count
);

  import adder_ser_pkg::*;

  localparam int CNT_W = $clog2(DATA_W);

  ser_state_t        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              ser_out_q, ser_out_d;
  logic              ser_busy_q;
  logic              overflow_q;

  logic              push, pop, full, empty;
  logic [DATA_W-1:0] rd_data;

  assign in_ready = ena & ~full;
  assign push     = in_valid & in_ready;

  result_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // bit_cnt counts down the remaining data bits; zero means the last bit is on the line.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ser_out_d = ser_out_q;
    pop       = 1'b0;
    if (ena) begin
      unique case (state_q)
        IDLE, STOP: begin
          if (!empty) begin
            pop       = 1'b1;
            shift_d   = rd_data;
            ser_out_d = START_BIT;
            state_d   = START;
          end else begin
            ser_out_d = STOP_BIT;
            state_d   = IDLE;
          end
        end
        START: begin
          ser_out_d = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = CNT_W'(DATA_W - 1);
          state_d   = DATA;
        end
        DATA: begin
          if (bit_cnt_q == '0) begin
            ser_out_d = STOP_BIT;
            state_d   = STOP;
          end else begin
            ser_out_d = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q - CNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      ser_out_q  <= STOP_BIT;
      ser_busy_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      ser_out_q  <= ser_out_d;
      ser_busy_q <= (state_d != IDLE);
      if (in_valid && ena && full) overflow_q <= 1'b1;
    end
  end

  assign ser_out  = ser_out_q;
  assign ser_busy = ser_busy_q;
  assign overflow = overflow_q;

endmodule
